// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding, default sizes and helpers for the serial arithmetic blocks
package arith_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SLICE_W = 8;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/slice_subtract_8bit.sv
// slice_subtract_8bit: one ripple slice of a + ~b + carry_in built from full-adder cells
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module slice_subtract_8bit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_slice,
    input  logic [W-1:0] b_slice,
    input  logic         carry_in,
    output logic [W-1:0] diff_slice,
    output logic         carry_out
);
    logic [W:0] c;
    assign c[0] = carry_in;
    for (genvar i = 0; i < W; i++) begin : g_fa
        fa_cell u_fa (
            .a (a_slice[i]),
            .b (~b_slice[i]),
            .ci(c[i]),
            .s (diff_slice[i]),
            .co(c[i+1])
        );
    end
    assign carry_out = c[W];
endmodule

// File: rtl/serial_select_subtractor.sv
// serial_select_subtractor: a - b - borrow_in computed one slice per clock, LSB first,
// behind registered valid/ready handshakes
module serial_select_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             overflow_out,
    output logic             zero_out
);
    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int IDX_W      = idx_bits(NUM_SLICES);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, in_ready_q, out_valid_q, borrow_q, ovf_q, zero_q;
    logic [SLICE_W-1:0] a_s, b_s, d_s;
    logic               c_o, last, bad_idx;

    always_comb begin
        a_s     = a_q[idx_q*SLICE_W +: SLICE_W];
        b_s     = b_q[idx_q*SLICE_W +: SLICE_W];
        diff_d  = diff_q;
        diff_d[idx_q*SLICE_W +: SLICE_W] = d_s;
        last    = 32'(idx_q) == 32'(NUM_SLICES - 1);
        bad_idx = 32'(idx_q) >= 32'(NUM_SLICES);
    end

    slice_subtract_8bit #(.W(SLICE_W)) u_slice (
        .a_slice   (a_s),
        .b_slice   (b_s),
        .carry_in  (carry_q),
        .diff_slice(d_s),
        .carry_out (c_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= ~(in_valid & in_ready_q);
                    if (in_valid && in_ready_q) begin
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        carry_q <= ~borrow_in;
                        idx_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (bad_idx) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        diff_q  <= diff_d;
                        carry_q <= c_o;
                        idx_q   <= idx_q + 1'b1;
                        // flags are taken from the completed word on the last slice edge
                        if (last) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            borrow_q    <= ~c_o;
                            ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                            zero_q      <= diff_d == '0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign diff_out     = diff_q;
    assign borrow_out   = borrow_q;
    assign overflow_out = ovf_q;
    assign zero_out     = zero_q;
endmodule

// File: tb/tb_serial_select_subtractor.sv
// tb_serial_select_subtractor: table plus random vectors against a scoreboard, with backpressure,
// ignored-input and asynchronous-abort sequences
module tb_serial_select_subtractor;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, borrow_in, out_valid, out_ready;
    logic        borrow_out, overflow_out, zero_out;
    logic [31:0] operand_a, operand_b, diff_out;

    always #5 clk = ~clk;

    serial_select_subtractor dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .borrow_in   (borrow_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .diff_out    (diff_out),
        .borrow_out  (borrow_out),
        .overflow_out(overflow_out),
        .zero_out    (zero_out)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        bin;
        logic [31:0] d;
        logic        bo, ov, z;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        bo, ov, z;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t e;
        logic [32:0] r;
        r    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        e.d  = r[31:0];
        e.bo = r[32];
        e.ov = (a[31] != b[31]) && (r[31] != a[31]);
        e.z  = r[31:0] == 32'd0;
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input exp_t e, input int hold, input bit junk);
        int          n;
        exp_t        x;
        logic [34:0] snap;
        wait_ready();
        operand_a = a;
        operand_b = b;
        borrow_in = bin;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid  = junk;
        operand_a = $urandom;
        operand_b = $urandom;
        borrow_in = 1'($urandom_range(0, 1));
        chk("in_ready_calc", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            operand_a = $urandom;
            operand_b = $urandom;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'd4);
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
            return;
        end
        x = sb.pop_front();
        chk("diff", 64'(diff_out), 64'(x.d));
        chk("borrow", 64'(borrow_out), 64'(x.bo));
        chk("overflow", 64'(overflow_out), 64'(x.ov));
        chk("zero", 64'(zero_out), 64'(x.z));
        snap = {diff_out, borrow_out, overflow_out, zero_out};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_fields", 64'({diff_out, borrow_out, overflow_out, zero_out}), 64'(snap));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [31:0] ra, rb;
        logic        rbin;
        tbl[0] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{32'h0F100A01, 32'h01BC0100, 1'b0, 32'h0D540901, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        operand_a = '0;
        operand_b = '0;
        borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fields", 64'({diff_out, borrow_out, overflow_out, zero_out}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready_valid", 64'(out_valid), 64'd0);
        chk("idle_out_ready_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            e = '{tbl[i].d, tbl[i].bo, tbl[i].ov, tbl[i].z};
            do_op(tbl[i].a, tbl[i].b, tbl[i].bin, e, (i == 5) ? 10 : 0, i == 4);
        end
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = (i == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            do_op(ra, rb, rbin, model(ra, rb, rbin), i % 3, 1'b0);
        end

        wait_ready();
        operand_a = 32'h12345678;
        operand_b = 32'h00000001;
        borrow_in = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_diff", 64'(diff_out), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h00000005, 32'h00000003, 1'b0, model(32'h5, 32'h3, 1'b0), 0, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
